// File: rtl/mux_tree_pipe.sv
// mux_tree_pipe: pipelined binary mux tree selecting one of N_IN channels.
// One registered 2:1 mux level per select bit, LSB first. A single global
// advance enable stalls every level together, so the tree behaves like a
// fixed-latency shift pipeline with ready/valid handshakes at both ends.
// Optional feature macro: MUX_TREE_PIPE_SEL_ERR_EN enables the out-of-range
// flag pipeline driving out_err; when undefined out_err is tied low.
module mux_tree_pipe #(
    parameter int N_IN = 8,
    parameter int W    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_IN*W-1:0]       in_data,
    input  logic [$clog2(N_IN)-1:0] in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [W-1:0]            out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_err
);

    localparam int SW  = $clog2(N_IN);
    localparam int L   = SW;
    // The tree is padded to a power of two with all-zero channels; this is
    // what pairs the last element of an odd-sized level with zero data and
    // what makes an out-of-range select return zero.
    localparam int PAD = 1 << SW;

    logic w_adv;

    assign w_adv    = out_ready | ~out_valid;
    assign in_ready = w_adv;

    genvar k;
    generate
        for (k = 0; k < L; k++) begin : g_lvl
            localparam int N_I = PAD >> k;
            localparam int N_O = N_I / 2;
            localparam int SI  = SW - k;

            logic [N_I*W-1:0] w_din;
            logic [SI-1:0]    w_sin;
            logic             w_vin;
            logic [N_O*W-1:0] r_dat;
            logic             r_vld;
`ifdef MUX_TREE_PIPE_SEL_ERR_EN
            logic             w_ein;
            logic             r_err;
`endif

            if (k == 0) begin : g_src
                // Level 0 input: the accepted channels widened with zero channels
                always_comb begin
                    w_din = '0;
                    w_din[N_IN*W-1:0] = in_data;
                end
                assign w_sin = in_sel;
                assign w_vin = in_valid;
`ifdef MUX_TREE_PIPE_SEL_ERR_EN
                if (PAD == N_IN) begin : g_oor
                    assign w_ein = 1'b0;
                end else begin : g_oor
                    assign w_ein = in_valid & (in_sel >= SW'(N_IN));
                end
`endif
            end else begin : g_src
                assign w_din = g_lvl[k-1].r_dat;
                assign w_sin = g_lvl[k-1].g_fwd.r_sel;
                assign w_vin = g_lvl[k-1].r_vld;
`ifdef MUX_TREE_PIPE_SEL_ERR_EN
                assign w_ein = g_lvl[k-1].r_err;
`endif
            end

            // Level k: resolve one select bit; data only moves with a valid item
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_dat <= '0;
                    r_vld <= 1'b0;
                end else if (w_adv) begin
                    r_vld <= w_vin;
                    if (w_vin) begin
                        for (int j = 0; j < N_O; j++) begin
                            r_dat[j*W +: W] <= w_sin[0] ? w_din[(2*j+1)*W +: W]
                                                        : w_din[(2*j)*W +: W];
                        end
                    end
                end
            end

            if (SI > 1) begin : g_fwd
                logic [SI-2:0] r_sel;

                // Carry the not-yet-consumed upper select bits to the next level
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_sel <= '0;
                    end else if (w_adv && w_vin) begin
                        r_sel <= w_sin[SI-1:1];
                    end
                end
            end

`ifdef MUX_TREE_PIPE_SEL_ERR_EN
            // Out-of-range flag rides with the item; already qualified by valid
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_err <= 1'b0;
                end else if (w_adv) begin
                    r_err <= w_ein;
                end
            end
`endif
        end
    endgenerate

    assign out_data  = g_lvl[L-1].r_dat;
    assign out_valid = g_lvl[L-1].r_vld;
`ifdef MUX_TREE_PIPE_SEL_ERR_EN
    assign out_err   = g_lvl[L-1].r_err;
`else
    assign out_err   = 1'b0;
`endif

endmodule

// File: doc/mux_tree_pipe.md
MUX_TREE_PIPE -- requirements
Module: mux_tree_pipe

Interface
REQ-001 SHALL have parameter N_IN, default 8: number of input channels; legal range 2..64, need not be a power of two.
REQ-002 SHALL have parameter W, default 8: bit width of each channel.
REQ-003 SHALL derive localparams SW = ceil(log2(N_IN)) (select width) and L = SW (pipeline depth, one stage per tree level).
REQ-004 Ports SHALL be (clock and reset first):
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  N_IN*W  flattened channels; channel i occupies bits [i*W +: W].
- in_sel  input  SW  channel select.
- in_valid  input  1  in_data/in_sel valid.
- in_ready  output  1  block accepts this cycle.
- out_data  output  W  selected channel.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts.
- out_err  output  1  selected channel out of range (see Configuration).
REQ-005 One clock; reset is asynchronous and active-low.

Function
REQ-006 SHALL implement a binary tree of 2:1 muxes, each level registered: stage k (k = 0..L-1) resolves in_sel bit k (LSB first); pairs at level k are (2j, 2j+1).
REQ-007 A level with an odd element count SHALL pair its last element with all-zero data.
REQ-008 Each stage SHALL carry a valid bit, the unconsumed upper select bits, and an out-of-range flag alongside its data.
REQ-009 Global advance enable SHALL be adv = out_ready | ~out_valid; all stages load only when adv = 1, otherwise hold.
REQ-010 in_ready SHALL equal adv (combinational); a transfer occurs when in_valid & in_ready.
REQ-011 On adv, stage 0 valid SHALL load in_valid; bubbles propagate and are not collapsed.
REQ-012 Latency SHALL be exactly L cycles from accept to out_valid under continuous out_ready = 1; throughput one transfer per cycle.
REQ-013 in_data/in_sel SHALL be sampled only at accept; later changes SHALL NOT affect in-flight items.
REQ-014 out_data/out_valid/out_err SHALL be registered outputs of stage L-1 and SHALL remain stable while out_valid & ~out_ready.
REQ-015 Items SHALL exit in acceptance order; none dropped or duplicated under any out_ready pattern.
REQ-016 in_sel >= N_IN SHALL yield out_data = 0.
REQ-017 Stage data SHALL NOT be reset-dependent for correctness beyond REQ-019; valid bits gate all meaning.

Reset
REQ-018 rst_n low SHALL asynchronously clear all stage valid bits, data, and flags.
REQ-019 During and after reset: out_valid = 0, out_data = 0, out_err = 0, in_ready = 1.
REQ-020 Reset mid-operation SHALL discard all in-flight items; none appear after release.

Configuration
REQ-021 Macro MUX_TREE_PIPE_SEL_ERR_EN SHALL control out-of-range reporting.
REQ-022 Defined: out_err SHALL be 1 coincident with out_valid for an item accepted with in_sel >= N_IN, else 0.
REQ-023 Undefined: out_err SHALL be tied to 0 and the flag pipeline SHALL be omitted; out_data rule REQ-016 unchanged.

Verification (N_IN=8, W=8, L=3 unless stated)
REQ-024 rst_n=0 -> out_valid=0, out_data=8'h00, out_err=0, in_ready=1.
REQ-025 Channels i = 8'h10+i, out_ready=1, in_valid=1 streaming in_sel 0..7 -> out_valid rises 3 cycles after first accept, out_data 8'h10..8'h17 on 8 consecutive cycles.
REQ-026 Pipeline full with sel 2,5,7, out_ready=0 for 4 cycles -> in_ready=0, out_data held 8'h12; out_ready=1 -> 8'h12, 8'h15, 8'h17 in order, no loss.
REQ-027 N_IN=5, in_sel=6 -> out_data=8'h00, out_err=1 with MUX_TREE_PIPE_SEL_ERR_EN, 0 without; in_sel=4 -> channel 4 data, out_err=0.
REQ-028 Three items in flight, rst_n pulsed low mid-cycle -> out_valid=0 immediately; after release no output until new accepts plus 3 cycles.
REQ-029 Alternating in_valid 1/0, out_ready=1 -> out_valid pattern reproduces input pattern delayed 3 cycles.
